// File: rtl/anton_neopixel_decoder.sv
// WS2812-style line receiver: pulse-width bit recovery, byte assembly and pixel-buffer writes.
// Defining ANTON_NEOPIXEL_DECODER_32BIT_EN adds input mode32 for the transmitter's 32-bit address layout.
module anton_neopixel_decoder #(
  parameter int BUFFER_END    = 255,
  parameter int BIT_THRESHOLD = 4,
  parameter int MIN_HIGH      = 1,
  parameter int MAX_HIGH      = 8,
  parameter int RESET_DETECT  = 300,
  localparam int BUFFER_BITS  = $clog2(BUFFER_END + 1)
) (
  input  logic                   clk7mhz,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   neoData,
`ifdef ANTON_NEOPIXEL_DECODER_32BIT_EN
  input  logic                   mode32,
`endif
  output logic                   wrValid,
  output logic [BUFFER_BITS-1:0] wrAddr,
  output logic [7:0]             wrData,
  output logic                   frameDone,
  output logic [BUFFER_BITS:0]   frameBytes,
  output logic                   overflow,
  output logic                   bitError,
  output logic                   busy
);
  localparam int AW       = BUFFER_BITS + 1;
  localparam int LOW_BITS = $clog2(RESET_DETECT + 1);

  localparam logic [3:0]          THR_C     = 4'(BIT_THRESHOLD);
  localparam logic [3:0]          MINH_C    = 4'(MIN_HIGH);
  localparam logic [3:0]          MAXH_C    = 4'(MAX_HIGH);
  localparam logic [LOW_BITS-1:0] RST_C     = LOW_BITS'(RESET_DETECT);
  localparam logic [LOW_BITS-1:0] LOW_ONE   = LOW_BITS'(1);
  localparam logic [AW-1:0]       LAST_ADDR = AW'(BUFFER_END);
  localparam logic [AW-1:0]       CNT_ONE   = AW'(1);
  localparam logic [AW-1:0]       CNT_TWO   = AW'(2);

  typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;

  state_t                 state_q;
  logic                   sync1_q, sync2_q, dly_q;
  logic [3:0]             highCnt_q;
  logic [LOW_BITS-1:0]    lowCnt_q;
  logic [2:0]             bitCnt_q;
  logic [AW-1:0]          byteCnt_q;
  logic [AW-1:0]          addrCnt_q;
  logic [1:0]             grpCnt_q;
  logic [6:0]             shift_q;
  logic                   mode32_q;
  logic                   wrValid_q, frameDone_q, overflow_q, bitError_q;
  logic [BUFFER_BITS-1:0] wrAddr_q;
  logic [7:0]             wrData_q;
  logic [AW-1:0]          frameBytes_q;

  logic [3:0]             highInc_d;
  logic [LOW_BITS-1:0]    lowInc_d;
  logic                   bit_d;
  logic [7:0]             byte_d;
  logic [AW-1:0]          addrNext_d;
  logic [1:0]             grpNext_d;
  logic                   rise_w, fall_w, mode32_w;

`ifdef ANTON_NEOPIXEL_DECODER_32BIT_EN
  assign mode32_w = mode32;
`else
  assign mode32_w = 1'b0;
`endif

  always_ff @(posedge clk7mhz) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      dly_q   <= 1'b0;
    end else begin
      sync1_q <= neoData;
      sync2_q <= sync1_q;
      dly_q   <= sync2_q;
    end
  end

  assign rise_w = sync2_q & ~dly_q;
  assign fall_w = ~sync2_q & dly_q;

  // In 32-bit layout the fourth slot of every address group is left for the unused byte.
  always_comb begin
    highInc_d  = (highCnt_q == 4'hF) ? highCnt_q : highCnt_q + 4'd1;
    lowInc_d   = (lowCnt_q == RST_C) ? lowCnt_q : lowCnt_q + LOW_ONE;
    bit_d      = (highCnt_q >= THR_C);
    byte_d     = {shift_q, bit_d};
    addrNext_d = addrCnt_q + ((mode32_q && grpCnt_q == 2'd2) ? CNT_TWO : CNT_ONE);
    grpNext_d  = (grpCnt_q == 2'd2) ? 2'd0 : grpCnt_q + 2'd1;
  end

  always_ff @(posedge clk7mhz) begin
    if (reset || !enable) begin
      state_q     <= SYNC;
      highCnt_q   <= '0;
      lowCnt_q    <= '0;
      bitCnt_q    <= '0;
      byteCnt_q   <= '0;
      addrCnt_q   <= '0;
      grpCnt_q    <= '0;
      shift_q     <= '0;
      mode32_q    <= 1'b0;
      wrValid_q   <= 1'b0;
      wrAddr_q    <= '0;
      wrData_q    <= '0;
      frameDone_q <= 1'b0;
      bitError_q  <= 1'b0;
      if (reset) begin
        frameBytes_q <= '0;
        overflow_q   <= 1'b0;
      end
    end else begin
      wrValid_q   <= 1'b0;
      frameDone_q <= 1'b0;
      bitError_q  <= 1'b0;
      case (state_q)
        SYNC: begin
          if (sync2_q) begin
            lowCnt_q <= '0;
          end else if (lowInc_d == RST_C) begin
            lowCnt_q <= '0;
            state_q  <= IDLE;
          end else begin
            lowCnt_q <= lowInc_d;
          end
        end
        IDLE: begin
          bitCnt_q  <= '0;
          byteCnt_q <= '0;
          addrCnt_q <= '0;
          grpCnt_q  <= '0;
          mode32_q  <= mode32_w;
          if (rise_w) begin
            overflow_q <= 1'b0;
            highCnt_q  <= 4'd1;
            lowCnt_q   <= '0;
            state_q    <= HIGH;
          end
        end
        HIGH: begin
          // The rising-edge tick already counted as high tick one.
          if (fall_w) begin
            if (highCnt_q < MINH_C) begin
              bitError_q <= 1'b1;
              lowCnt_q   <= '0;
              state_q    <= SYNC;
            end else begin
              shift_q  <= byte_d[6:0];
              bitCnt_q <= bitCnt_q + 3'd1;
              lowCnt_q <= LOW_ONE;
              state_q  <= LOW;
              if (bitCnt_q == 3'd7) begin
                if (addrCnt_q <= LAST_ADDR) begin
                  wrValid_q <= 1'b1;
                  wrAddr_q  <= addrCnt_q[BUFFER_BITS-1:0];
                  wrData_q  <= byte_d;
                  byteCnt_q <= byteCnt_q + CNT_ONE;
                  addrCnt_q <= addrNext_d;
                  grpCnt_q  <= grpNext_d;
                end else begin
                  overflow_q <= 1'b1;
                end
              end
            end
          end else if (highInc_d > MAXH_C) begin
            bitError_q <= 1'b1;
            lowCnt_q   <= '0;
            state_q    <= SYNC;
          end else begin
            highCnt_q <= highInc_d;
          end
        end
        LOW: begin
          if (rise_w) begin
            highCnt_q <= 4'd1;
            lowCnt_q  <= '0;
            state_q   <= HIGH;
          end else if (lowInc_d == RST_C) begin
            frameDone_q  <= 1'b1;
            frameBytes_q <= byteCnt_q;
            bitError_q   <= (bitCnt_q != 3'd0);
            lowCnt_q     <= '0;
            state_q      <= IDLE;
          end else begin
            lowCnt_q <= lowInc_d;
          end
        end
        default: state_q <= SYNC;
      endcase
    end
  end

  assign wrValid    = wrValid_q;
  assign wrAddr     = wrAddr_q;
  assign wrData     = wrData_q;
  assign frameDone  = frameDone_q;
  assign frameBytes = frameBytes_q;
  assign overflow   = overflow_q;
  assign bitError   = bitError_q;
  assign busy       = (state_q == HIGH) || (state_q == LOW);

endmodule

// File: tb/tb_anton_neopixel_decoder.sv
// Directed bench: a full-size decoder and a 4-byte-buffer decoder share one stimulus line.
module tb_anton_neopixel_decoder;
  logic clk7mhz = 1'b0;
  logic reset, enable, neoData;
`ifdef ANTON_NEOPIXEL_DECODER_32BIT_EN
  logic mode32;
`endif

  always #5 clk7mhz = ~clk7mhz;

  logic       b_wrValid, b_frameDone, b_overflow, b_bitError, b_busy;
  logic [7:0] b_wrAddr, b_wrData;
  logic [8:0] b_frameBytes;
  logic       s_wrValid, s_frameDone, s_overflow, s_bitError, s_busy;
  logic [1:0] s_wrAddr;
  logic [7:0] s_wrData;
  logic [2:0] s_frameBytes;

  anton_neopixel_decoder dut_big (
    .clk7mhz(clk7mhz), .reset(reset), .enable(enable), .neoData(neoData),
`ifdef ANTON_NEOPIXEL_DECODER_32BIT_EN
    .mode32(mode32),
`endif
    .wrValid(b_wrValid), .wrAddr(b_wrAddr), .wrData(b_wrData), .frameDone(b_frameDone),
    .frameBytes(b_frameBytes), .overflow(b_overflow), .bitError(b_bitError), .busy(b_busy)
  );

  anton_neopixel_decoder #(.BUFFER_END(3)) dut_small (
    .clk7mhz(clk7mhz), .reset(reset), .enable(enable), .neoData(neoData),
`ifdef ANTON_NEOPIXEL_DECODER_32BIT_EN
    .mode32(mode32),
`endif
    .wrValid(s_wrValid), .wrAddr(s_wrAddr), .wrData(s_wrData), .frameDone(s_frameDone),
    .frameBytes(s_frameBytes), .overflow(s_overflow), .bitError(s_bitError), .busy(s_busy)
  );

  // Event log, written only by this monitor.
  int b_addr_q[$];
  int b_data_q[$];
  int s_addr_q[$];
  int b_fd = 0, b_be = 0, b_coinc = 0, s_fd = 0;

  always @(negedge clk7mhz) begin
    if (b_wrValid) begin
      b_addr_q.push_back(int'(b_wrAddr));
      b_data_q.push_back(int'(b_wrData));
    end
    if (s_wrValid) s_addr_q.push_back(int'(s_wrAddr));
    if (b_frameDone) b_fd++;
    if (b_bitError) b_be++;
    if (b_frameDone && b_bitError) b_coinc++;
    if (s_frameDone) s_fd++;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk7mhz);
  endtask

  task automatic send_bit(input logic b);
    neoData = 1'b1;
    cyc(b ? 5 : 2);
    neoData = 1'b0;
    cyc(b ? 3 : 6);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  typedef struct {
    int          n;
    logic [47:0] dat;
    int          b_fb;
    int          s_fb;
    int          s_ovf;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int bw, sw, bfd, bbe, sfd, nb, ns, first;
    logic [7:0] d8;

    vecs[0] = '{1, 48'hA5_00_00_00_00_00, 1, 1, 0};
    vecs[1] = '{3, 48'h12_34_56_00_00_00, 3, 3, 0};
    vecs[2] = '{1, 48'hFF_00_00_00_00_00, 1, 1, 0};
    vecs[3] = '{6, 48'h01_02_03_04_05_06, 6, 4, 1};

    reset = 1'b1; enable = 1'b1; neoData = 1'b0;
`ifdef ANTON_NEOPIXEL_DECODER_32BIT_EN
    mode32 = 1'b0;
`endif
    cyc(3);
    chk("reset_big_outputs", int'({b_wrValid, b_wrAddr, b_wrData, b_frameDone, b_frameBytes,
                                   b_overflow, b_bitError, b_busy}), 0);
    chk("reset_small_outputs", int'({s_wrValid, s_wrAddr, s_wrData, s_frameDone, s_frameBytes,
                                     s_overflow, s_bitError, s_busy}), 0);
    reset = 1'b0;
    cyc(310);

    for (int v = 0; v < 4; v++) begin
      bw = b_addr_q.size(); sw = s_addr_q.size();
      bfd = b_fd; bbe = b_be; sfd = s_fd;
      for (int k = 0; k < vecs[v].n; k++) send_byte(vecs[v].dat[47 - 8*k -: 8]);
      neoData = 1'b0;
      cyc(400);
      nb = b_addr_q.size() - bw;
      ns = s_addr_q.size() - sw;
      chk($sformatf("v%0d_big_writes", v), nb, vecs[v].n);
      for (int k = 0; k < nb && k < vecs[v].n; k++) begin
        d8 = vecs[v].dat[47 - 8*k -: 8];
        chk($sformatf("v%0d_big_addr%0d", v, k), b_addr_q[bw + k], k);
        chk($sformatf("v%0d_big_data%0d", v, k), b_data_q[bw + k], int'(d8));
      end
      chk($sformatf("v%0d_small_writes", v), ns, vecs[v].s_fb);
      for (int k = 0; k < ns && k < vecs[v].s_fb; k++)
        chk($sformatf("v%0d_small_addr%0d", v, k), s_addr_q[sw + k], k);
      chk($sformatf("v%0d_big_frameDone", v), b_fd - bfd, 1);
      chk($sformatf("v%0d_small_frameDone", v), s_fd - sfd, 1);
      chk($sformatf("v%0d_big_frameBytes", v), int'(b_frameBytes), vecs[v].b_fb);
      chk($sformatf("v%0d_small_frameBytes", v), int'(s_frameBytes), vecs[v].s_fb);
      chk($sformatf("v%0d_small_overflow", v), int'(s_overflow), vecs[v].s_ovf);
      chk($sformatf("v%0d_big_overflow", v), int'(b_overflow), 0);
      chk($sformatf("v%0d_bitError", v), b_be - bbe, 0);
    end

    // Overflow clears on the first rising edge of the next frame; then a stuck-high line.
    bw = b_addr_q.size(); bbe = b_be; bfd = b_fd;
    neoData = 1'b1;
    cyc(4);
    chk("ovf_clear_on_rise", int'(s_overflow), 0);
    chk("busy_in_frame", int'(b_busy), 1);
    cyc(1);
    neoData = 1'b0;
    cyc(3);
    d8 = 8'hD5;
    for (int i = 6; i >= 0; i--) send_bit(d8[i]);
    neoData = 1'b1;
    first = 0;
    for (int k = 1; k <= 20; k++) begin
      cyc(1);
      if (b_bitError && first == 0) first = k;
    end
    neoData = 1'b0;
    cyc(3);
    send_byte(8'hAA);
    neoData = 1'b0;
    cyc(400);
    chk("stuck_high_error_cycle", first, 11);
    chk("stuck_high_error_count", b_be - bbe, 1);
    chk("stuck_high_writes", b_addr_q.size() - bw, 1);
    if (b_addr_q.size() > bw) chk("stuck_high_prior_data", b_data_q[bw], 8'hD5);
    chk("stuck_high_no_frameDone", b_fd - bfd, 0);

    // Partial byte at end of frame.
    bw = b_addr_q.size(); bbe = b_be; bfd = b_fd;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    cyc(400);
    chk("partial_frameDone", b_fd - bfd, 1);
    chk("partial_frameBytes", int'(b_frameBytes), 0);
    chk("partial_bitError", b_be - bbe, 1);
    chk("partial_coincident", b_coinc, 1);
    chk("partial_no_write", b_addr_q.size() - bw, 0);

    // Reset mid-byte, then a frame with no preceding long low.
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    neoData = 1'b1;
    cyc(3);
    reset = 1'b1;
    cyc(1);
    chk("midreset_busy", int'(b_busy), 0);
    chk("midreset_wrData", int'(b_wrData), 0);
    chk("midreset_others", int'({b_wrValid, b_wrAddr, b_frameDone, b_frameBytes,
                                 b_overflow, b_bitError}), 0);
    reset = 1'b0;
    neoData = 1'b0;
    bw = b_addr_q.size(); bfd = b_fd;
    cyc(2);
    send_byte(8'h3C);
    neoData = 1'b0;
    cyc(400);
    chk("unsynced_no_write", b_addr_q.size() - bw, 0);
    chk("unsynced_no_frameDone", b_fd - bfd, 0);

`ifdef ANTON_NEOPIXEL_DECODER_32BIT_EN
    mode32 = 1'b1;
    bw = b_addr_q.size();
    cyc(2);
    for (int k = 0; k < 6; k++) send_byte(8'(8'h10 + k));
    neoData = 1'b0;
    cyc(400);
    begin
      int exp_addr[6] = '{0, 1, 2, 4, 5, 6};
      chk("m32_writes", b_addr_q.size() - bw, 6);
      for (int k = 0; k < 6 && bw + k < b_addr_q.size(); k++)
        chk($sformatf("m32_addr%0d", k), b_addr_q[bw + k], exp_addr[k]);
      chk("m32_frameBytes", int'(b_frameBytes), 6);
    end
    mode32 = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
